// File: rtl/icache_ctrl.sv
// icache_ctrl: lookup/refill sequencer for a direct-mapped I-cache with per-set valid bits and set invalidation.
module icache_ctrl #(
  parameter int TAG_W = 20,
  parameter int IDX_W = 7,
  parameter int NWORD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [31:0]           cpu_addr,
  output logic                  cpu_addr_ok,
  output logic                  cpu_data_ok,
  output logic [31:0]           cpu_rdata,
  input  logic                  inv_req,
  input  logic [IDX_W-1:0]      inv_idx,
  output logic                  inv_ok,
  output logic [31:0]           bank_addr,
  output logic [NWORD-1:0]      bank_we,
  output logic [31:0]           bank_wdata,
  input  logic [32*NWORD-1:0]   bank_rdata,
  output logic [IDX_W-1:0]      tag_addr,
  output logic                  tag_we,
  output logic [TAG_W-1:0]      tag_wdata,
  input  logic [TAG_W-1:0]      tag_rdata,
  output logic                  rd_req,
  output logic [31:0]           rd_addr,
  input  logic                  rd_rdy,
  input  logic                  ret_valid,
  input  logic                  ret_last,
  input  logic [31:0]           ret_data
);
  localparam int OW = $clog2(NWORD);
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, RESP} state_t;
  state_t state, state_n;
  logic [(1<<IDX_W)-1:0] valid;
  logic [31:0] req_addr, crit_word;
  logic [OW-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic hit;
  assign idx = req_addr[OW+2 +: IDX_W];
  assign hit = valid[idx] && tag_rdata == req_addr[31 -: TAG_W];
  // Outputs are forced low while rst is high so reset takes effect immediately.
  always_comb begin
    state_n = state;
    cpu_addr_ok = 1'b0;
    cpu_data_ok = 1'b0;
    cpu_rdata = '0;
    inv_ok = 1'b0;
    bank_addr = '0;
    bank_we = '0;
    bank_wdata = '0;
    tag_addr = '0;
    tag_we = 1'b0;
    tag_wdata = '0;
    rd_req = 1'b0;
    rd_addr = '0;
    if (!rst) begin
      bank_addr = req_addr;
      tag_addr = idx;
      case (state)
        IDLE: begin
          bank_addr = cpu_addr;
          tag_addr = cpu_addr[OW+2 +: IDX_W];
          inv_ok = inv_req;
          cpu_addr_ok = !inv_req;
          state_n = cpu_req && !inv_req ? LOOKUP : IDLE;
        end
        LOOKUP: begin
          if (hit) begin
            cpu_data_ok = 1'b1;
            cpu_rdata = bank_rdata[32*req_addr[OW+1:2] +: 32];
            cpu_addr_ok = 1'b1;
            bank_addr = cpu_addr;
            tag_addr = cpu_addr[OW+2 +: IDX_W];
          end
          state_n = !hit ? MISS : cpu_req ? LOOKUP : IDLE;
        end
        MISS: begin
          rd_req = 1'b1;
          rd_addr = {req_addr[31:OW+2], {(OW+2){1'b0}}};
          state_n = rd_rdy ? REFILL : MISS;
        end
        REFILL: begin
          if (ret_valid) begin
            bank_we = {{(NWORD-1){1'b0}}, 1'b1} << cnt;
            bank_wdata = ret_data;
            tag_we = ret_last;
            tag_wdata = ret_last ? req_addr[31 -: TAG_W] : '0;
            state_n = ret_last ? RESP : REFILL;
          end
        end
        RESP: begin
          cpu_data_ok = 1'b1;
          cpu_rdata = crit_word;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      req_addr <= '0;
      cnt <= '0;
      crit_word <= '0;
    end else begin
      state <= state_n;
      if (cpu_req && cpu_addr_ok) req_addr <= cpu_addr;
      if (inv_ok) valid[inv_idx] <= 1'b0;
      if (tag_we) valid[idx] <= 1'b1;
      if (rd_req && rd_rdy) cnt <= '0;
      else if (|bank_we) cnt <= cnt + 1'b1;
      if (|bank_we && cnt == req_addr[OW+1:2]) crit_word <= ret_data;
    end
  end
endmodule
